// File: rtl/regfile_wb_queue_if.sv
// Writeback handshake bundle between the retiring pipeline stage (master)
// and the RegFile writeback queue (slave).
interface regfile_wb_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output we, output addr, output data, input ready);
  modport slave  (input valid, input we, input addr, input data, output ready);
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue feeding the RegFile write port one entry per clock,
// with newest-match bypass of pending entries onto both operand read ports.
module regfile_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_queue_if.slave      wb,
  output logic                   rg_wrt_en,
  output logic [ADDR_W-1:0]      rg_wrt_addr,
  output logic [DATA_W-1:0]      rg_wrt_data,
  input  logic [ADDR_W-1:0]      byp_addr1,
  input  logic [ADDR_W-1:0]      byp_addr2,
  input  logic [DATA_W-1:0]      rf_rd_data1,
  input  logic [DATA_W-1:0]      rf_rd_data2,
  output logic [DATA_W-1:0]      byp_data1,
  output logic [DATA_W-1:0]      byp_data2,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [15:0]            commit_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [15:0]       commit_reg, commit_next;
  logic [ADDR_W-1:0] last_addr_reg, last_addr_next;
  logic [DATA_W-1:0] last_data_reg, last_data_next;

  logic accept, push, pop;

  assign wb.ready = (count_reg < CNT_W'(DEPTH));
  assign accept   = wb.valid && wb.ready;
  // Non-writes and x0 writes complete the handshake but never occupy a slot.
  assign push     = accept && wb.we && (wb.addr != '0);
  assign pop      = (count_reg != '0);

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    commit_next    = commit_reg;
    last_addr_next = last_addr_reg;
    last_data_next = last_data_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next    = rd_ptr_reg + 1'b1;
      commit_next    = commit_reg + 16'd1;
      last_addr_next = mem_addr[rd_ptr_reg];
      last_data_next = mem_data[rd_ptr_reg];
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      commit_reg    <= '0;
      last_addr_reg <= '0;
      last_data_reg <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      commit_reg    <= commit_next;
      last_addr_reg <= last_addr_next;
      last_data_reg <= last_data_next;
    end
  end

  // Storage needs no reset: an entry is only observed while it is counted as pending.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_reg] <= wb.addr;
      mem_data[wr_ptr_reg] <= wb.data;
    end
  end

  // Once empty, the write port keeps presenting the last committed entry.
  assign rg_wrt_en   = pop;
  assign rg_wrt_addr = pop ? mem_addr[rd_ptr_reg] : last_addr_reg;
  assign rg_wrt_data = pop ? mem_data[rd_ptr_reg] : last_data_reg;
  assign q_count     = count_reg;
  assign commit_cnt  = commit_reg;

  // Walk pending entries oldest to newest so the newest match wins.
  always_comb begin
    byp_data1 = rf_rd_data1;
    byp_data2 = rf_rd_data2;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_reg) begin
        if (mem_addr[rd_ptr_reg + PTR_W'(k)] == byp_addr1) begin
          byp_data1 = mem_data[rd_ptr_reg + PTR_W'(k)];
        end
        if (mem_addr[rd_ptr_reg + PTR_W'(k)] == byp_addr2) begin
          byp_data2 = mem_data[rd_ptr_reg + PTR_W'(k)];
        end
      end
    end
    if (byp_addr1 == '0) byp_data1 = '0;
    if (byp_addr2 == '0) byp_data2 = '0;
  end
endmodule
